// File: rtl/font_rom_arbiter_if.sv
// Requester-side bus of the font ROM arbiter: two read ports sharing one
// registered data return.
interface font_rom_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12
);
    logic                  p0_req;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic                  p0_gnt;
    logic                  p0_rvalid;
    logic                  p1_req;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic                  p1_gnt;
    logic                  p1_rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    // Requesters drive req/addr and receive grants and returned data
    modport master (
        output p0_req, p0_addr, p1_req, p1_addr,
        input  p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, rdata
    );

    modport slave (
        input  p0_req, p0_addr, p1_req, p1_addr,
        output p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, rdata
    );
endinterface

// File: rtl/font_rom_arbiter.sv
// Two-port arbiter for the single-read-port font ROM: port 0 has priority,
// and port 1 is guaranteed a slot after MAX_WAIT consecutive losing cycles.
module font_rom_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12,
    parameter int ROM_LAT    = 1,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    font_rom_arbiter_if.slave     bus,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [7:0]            starve_cnt
);
    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
    localparam int         TAG_DEPTH  = ROM_LAT + 1;

    logic                 force1;
    logic                 grant_p0;
    logic                 grant_p1;
    logic                 issue;
    logic [TAG_DEPTH-1:0] tag_valid;
    logic [TAG_DEPTH-1:0] tag_port;
    logic                 exit_valid;
    logic                 exit_port;
    logic                 p0_rvalid_q;
    logic                 p1_rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Grants are held low during reset so nothing is issued into a clearing pipeline
    always_comb begin
        force1   = bus.p1_req && (starve_cnt >= MAX_WAIT_C);
        grant_p1 = rst_n && bus.p1_req && (!bus.p0_req || force1);
        grant_p0 = rst_n && bus.p0_req && !grant_p1;
        issue    = grant_p0 || grant_p1;
    end

    assign bus.p0_gnt    = grant_p0;
    assign bus.p1_gnt    = grant_p1;
    assign bus.p0_rvalid = p0_rvalid_q;
    assign bus.p1_rvalid = p1_rvalid_q;
    assign bus.rdata     = rdata_q;

    assign exit_valid = tag_valid[TAG_DEPTH-1];
    assign exit_port  = tag_port[TAG_DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
        end else if (grant_p1) begin
            rom_addr <= bus.p1_addr;
        end else if (grant_p0) begin
            rom_addr <= bus.p0_addr;
        end
    end

    // One tag per issued read; it reaches the last stage when rom_q holds its word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid <= '0;
            tag_port  <= '0;
        end else begin
            tag_valid <= {tag_valid[TAG_DEPTH-2:0], issue};
            tag_port  <= {tag_port[TAG_DEPTH-2:0], grant_p1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            p0_rvalid_q <= exit_valid && !exit_port;
            p1_rvalid_q <= exit_valid && exit_port;
            if (exit_valid) begin
                rdata_q <= rom_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 8'd0;
        end else if (!bus.p1_req || grant_p1) begin
            starve_cnt <= 8'd0;
        end else if (starve_cnt != 8'hFF) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end
endmodule
